// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (req 0)
// and load (req 1) writeback paths; port drive is registered, grants are combinational.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         req0Valid,
    input  logic [ADDR_WIDTH-1:0]        req0Reg,
    input  logic [DATA_WIDTH-1:0]        req0Data,
    output logic                         req0Ready,
    input  logic                         req1Valid,
    input  logic [ADDR_WIDTH-1:0]        req1Reg,
    input  logic [DATA_WIDTH-1:0]        req1Data,
    output logic                         req1Ready,
    output logic [ADDR_WIDTH-1:0]        writeRegister,
    output logic [DATA_WIDTH-1:0]        writeData,
    output logic                         regWrite,
    output logic [(1<<ADDR_WIDTH)-1:0]   pendingMask,
    output logic                         lastGrant
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // Handshake: a write transfers on the rising edge where reqNValid & reqNReady are both 1.
    // Ready is a pure function of the valids, stall and r_lastGrant; a requester that sees
    // valid & !ready must hold its reg/data stable until it is granted.
    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_any_grant;
    logic [ADDR_WIDTH-1:0]  w_sel_reg;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    logic [ADDR_WIDTH-1:0]  r_writeRegister;
    logic [DATA_WIDTH-1:0]  r_writeData;
    logic                   r_regWrite;
    logic                   r_lastGrant;

    always_comb begin
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        if (!stall) begin
            w_grant0 = req0Valid && (!req1Valid || r_lastGrant);
            w_grant1 = req1Valid && (!req0Valid || !r_lastGrant);
        end
        w_any_grant = w_grant0 || w_grant1;
        w_sel_reg   = w_grant1 ? req1Reg  : req0Reg;
        w_sel_data  = w_grant1 ? req1Data : req0Data;
    end

    assign req0Ready = w_grant0;
    assign req1Ready = w_grant1;

    // Register 0 is hardwired; its writes are accepted but never enable the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regWrite      <= 1'b0;
            r_writeRegister <= '0;
            r_writeData     <= '0;
            r_lastGrant     <= 1'b1;
        end else if (w_any_grant) begin
            r_regWrite      <= (w_sel_reg != '0);
            r_writeRegister <= w_sel_reg;
            r_writeData     <= w_sel_data;
            r_lastGrant     <= w_grant1;
        end else begin
            r_regWrite      <= 1'b0;
        end
    end

    always_comb begin
        pendingMask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (r_regWrite && (r_writeRegister == ADDR_WIDTH'(i))) begin
                pendingMask[i] = 1'b1;
            end
        end
    end

    assign writeRegister = r_writeRegister;
    assign writeData     = r_writeData;
    assign regWrite      = r_regWrite;
    assign lastGrant     = r_lastGrant;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a random phase, checked
// against a reference model whose predicted port state flows through a scoreboard queue.
module tb_regfile_write_arbiter;

    localparam int W = 39;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req0Valid;
    logic [4:0]  req0Reg;
    logic [31:0] req0Data;
    logic        req0Ready;
    logic        req1Valid;
    logic [4:0]  req1Reg;
    logic [31:0] req1Data;
    logic        req1Ready;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [31:0] pendingMask;
    logic        lastGrant;

    logic [W-1:0] exp_q[$];
    int           pass_cnt = 0;
    int           chk_cnt  = 0;

    logic        m_g0, m_g1, m_we, m_last;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0Valid(req0Valid), .req0Reg(req0Reg), .req0Data(req0Data), .req0Ready(req0Ready),
        .req1Valid(req1Valid), .req1Reg(req1Reg), .req1Data(req1Data), .req1Ready(req1Ready),
        .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
        .pendingMask(pendingMask), .lastGrant(lastGrant)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_port(input logic [W-1:0] e);
        logic [31:0] mask;
        mask = e[38] ? (32'd1 << e[37:33]) : 32'd0;
        check_val("regWrite",      W'(regWrite),      W'(e[38]));
        check_val("writeRegister", W'(writeRegister), W'(e[37:33]));
        check_val("writeData",     W'(writeData),     W'(e[32:1]));
        check_val("lastGrant",     W'(lastGrant),     W'(e[0]));
        check_val("pendingMask",   W'(pendingMask),   W'(mask));
    endtask

    // One clock: drive at posedge+1, check ready at negedge, check port after the edge.
    task automatic drive_cycle(input logic rst, input logic st,
                               input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        logic [W-1:0] e;
        reset = rst; stall = st;
        req0Valid = v0; req0Reg = a0; req0Data = d0;
        req1Valid = v1; req1Reg = a1; req1Data = d1;
        @(negedge clk);
        m_g0 = !st && v0 && (!v1 || m_last);
        m_g1 = !st && v1 && (!v0 || !m_last);
        check_val("req0Ready", W'(req0Ready), W'(m_g0));
        check_val("req1Ready", W'(req1Ready), W'(m_g1));
        if (rst) begin
            m_we = 1'b0; m_reg = '0; m_data = '0; m_last = 1'b1;
        end else if (m_g0 || m_g1) begin
            m_reg  = m_g0 ? a0 : a1;
            m_data = m_g0 ? d0 : d1;
            m_we   = (m_reg != 5'd0);
            m_last = m_g1;
        end else begin
            m_we = 1'b0;
        end
        exp_q.push_back({m_we, m_reg, m_data, m_last});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", W'(1), W'(0));
        end else begin
            e = exp_q.pop_front();
            check_port(e);
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic        p0v, p1v, st;
        logic [4:0]  p0a, p1a;
        logic [31:0] p0d, p1d;

        reset = 1'b1; stall = 1'b0;
        req0Valid = 1'b0; req0Reg = '0; req0Data = '0;
        req1Valid = 1'b0; req1Reg = '0; req1Data = '0;
        repeat (2) @(posedge clk);
        #1;
        m_we = 1'b0; m_reg = '0; m_data = '0; m_last = 1'b1;
        check_port({1'b0, 5'd0, 32'd0, 1'b1});

        // Single requester 0 write.
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle_cycle();

        // Continuous contention from reset: grants alternate 0,1,0,1.
        drive_cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);

        // Same-register contention with lastGrant=1: loser's data lands last.
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        drive_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0,    1'b1, 5'd7, 32'hBBBB);

        // Register 0 write is accepted but does not enable the port.
        drive_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);

        // Stall with both valid, following a fresh write so the drain is visible.
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0, 32'd0);
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);

        // Transfer followed by reset; a grant during reset is dropped.
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd9, 32'h5A5A, 1'b0, 5'd0, 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h7777);
        idle_cycle();

        // Random traffic; a requester holds its request until granted.
        p0v = 1'b1; p0a = 5'd1; p0d = 32'h1;
        p1v = 1'b1; p1a = 5'd2; p1d = 32'h2;
        for (int i = 0; i < 80; i++) begin
            st = ($urandom_range(0, 6) == 0);
            drive_cycle(1'b0, st, p0v, p0a, p0d, p1v, p1a, p1d);
            if (m_g0 || !p0v) begin
                p0v = ($urandom_range(0, 3) != 0);
                p0a = 5'($urandom_range(0, 31));
                p0d = $urandom;
            end
            if (m_g1 || !p1v) begin
                p1v = ($urandom_range(0, 3) != 0);
                p1a = 5'($urandom_range(0, 31));
                p1d = $urandom;
            end
        end
        idle_cycle();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
